// File: rtl/encoder_pkg.sv
// Shared constants and FSM state encoding for the encoder MAC scheduler.
package encoder_pkg;

   localparam int DEF_N_INPUT  = 9;
   localparam int DEF_M_OUTPUT = 4;
   localparam int DEF_BITSIZE  = 32;
   localparam int DEF_FRAC     = 26;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/encoder_mac_sched_fxp_mac.sv
// Combinational fixed-point multiply-accumulate: sum = acc + floor(a*b / 2^FRAC),
// all arithmetic wrapping modulo 2^BITSIZE.
module fxp_mac import encoder_pkg::*; #(
   parameter int BITSIZE = DEF_BITSIZE,
   parameter int FRAC    = DEF_FRAC
) (
   input  logic [BITSIZE-1:0] acc_i,
   input  logic [BITSIZE-1:0] a_i,
   input  logic [BITSIZE-1:0] b_i,
   output logic [BITSIZE-1:0] sum_o
);

   logic signed [2*BITSIZE-1:0] a_ext, b_ext, prod, shifted;

   always_comb begin
      a_ext   = {{BITSIZE{a_i[BITSIZE-1]}}, a_i};
      b_ext   = {{BITSIZE{b_i[BITSIZE-1]}}, b_i};
      prod    = a_ext * b_ext;
      // Arithmetic shift of the signed product rounds toward minus infinity.
      shifted = prod >>> FRAC;
      sum_o   = acc_i + shifted[BITSIZE-1:0];
   end

endmodule

// File: rtl/encoder_mac_sched.sv
// Encoder layer scheduler: latches x/w/b on start, then walks one shared MAC
// over every (output j, input i) term and publishes out[j] as each row finishes.
module encoder_mac_sched import encoder_pkg::*; #(
   parameter int N_INPUT  = DEF_N_INPUT,
   parameter int M_OUTPUT = DEF_M_OUTPUT,
   parameter int BITSIZE  = DEF_BITSIZE,
   parameter int FRAC     = DEF_FRAC
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [N_INPUT*BITSIZE-1:0]            x,
   input  logic [N_INPUT*M_OUTPUT*BITSIZE-1:0]   w,
   input  logic [M_OUTPUT*BITSIZE-1:0]           b,
   output logic [M_OUTPUT*BITSIZE-1:0]           out,
   output logic                                  busy,
   output logic                                  done
);

   localparam int IW = (N_INPUT > 1) ? $clog2(N_INPUT) : 1;
   localparam int JW = (M_OUTPUT > 1) ? $clog2(M_OUTPUT) : 1;
   localparam int KW = (N_INPUT * M_OUTPUT > 1) ? $clog2(N_INPUT * M_OUTPUT) : 1;
   localparam logic [IW-1:0] I_LAST = IW'(N_INPUT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(M_OUTPUT - 1);

   state_t             state_q;
   logic [IW-1:0]      i_q;
   logic [JW-1:0]      j_q;
   logic [KW-1:0]      k_q;
   logic [BITSIZE-1:0] acc_q;
   logic [BITSIZE-1:0] acc_d;
   logic [BITSIZE-1:0] acc_seed;
   logic [BITSIZE-1:0] x_cur;
   logic [BITSIZE-1:0] w_cur;
   logic [BITSIZE-1:0] x_q   [N_INPUT];
   logic [BITSIZE-1:0] w_q   [N_INPUT*M_OUTPUT];
   logic [BITSIZE-1:0] b_q   [M_OUTPUT];
   logic [BITSIZE-1:0] out_q [M_OUTPUT];
   logic               busy_q;
   logic               done_q;

   // k_q tracks the flat weight index j*N_INPUT+i alongside the i/j counters.
   always_comb begin
      acc_seed = (i_q == '0) ? b_q[j_q] : acc_q;
      x_cur    = x_q[i_q];
      w_cur    = w_q[k_q];
   end

   fxp_mac #(
      .BITSIZE (BITSIZE),
      .FRAC    (FRAC)
   ) u_mac (
      .acc_i (acc_seed),
      .a_i   (x_cur),
      .b_i   (w_cur),
      .sum_o (acc_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int unsigned n = 0; n < N_INPUT; n++) x_q[n] <= '0;
         for (int unsigned n = 0; n < N_INPUT*M_OUTPUT; n++) w_q[n] <= '0;
         for (int unsigned n = 0; n < M_OUTPUT; n++) begin
            b_q[n]   <= '0;
            out_q[n] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  for (int unsigned n = 0; n < N_INPUT; n++)
                     x_q[n] <= x[n*BITSIZE +: BITSIZE];
                  for (int unsigned n = 0; n < N_INPUT*M_OUTPUT; n++)
                     w_q[n] <= w[n*BITSIZE +: BITSIZE];
                  for (int unsigned n = 0; n < M_OUTPUT; n++)
                     b_q[n] <= b[n*BITSIZE +: BITSIZE];
                  i_q     <= '0;
                  j_q     <= '0;
                  k_q     <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_MAC;
               end
            end
            S_MAC: begin
               acc_q <= acc_d;
               k_q   <= k_q + 1'b1;
               if (i_q == I_LAST) begin
                  out_q[j_q] <= acc_d;
                  i_q        <= '0;
                  if (j_q == J_LAST) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end else begin
                  i_q <= i_q + 1'b1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      out = '0;
      for (int unsigned n = 0; n < M_OUTPUT; n++)
         out[n*BITSIZE +: BITSIZE] = out_q[n];
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: doc/encoder_mac_sched.md
ENCODER_MAC_SCHED -- requirements
Module: encoder_mac_sched

Interface
REQ-001 SHALL have parameter N_INPUT, default 9, number of input features per vector.
REQ-002 SHALL have parameter M_OUTPUT, default 4, number of output neurons.
REQ-003 SHALL have parameter BITSIZE, default 32, word width, signed two's complement.
REQ-004 SHALL have parameter FRAC, default 26, fractional bits (Q6.26 at defaults; 1.0 = 0x0400_0000).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  request to compute one encoder pass.
REQ-008 SHALL have port x  input  N_INPUT*BITSIZE  input vector; x[i] at bits [i*BITSIZE +: BITSIZE].
REQ-009 SHALL have port w  input  N_INPUT*M_OUTPUT*BITSIZE  weights; w for output j, input i at word index j*N_INPUT+i.
REQ-010 SHALL have port b  input  M_OUTPUT*BITSIZE  bias; b[j] at word index j.
REQ-011 SHALL have port out  output  M_OUTPUT*BITSIZE  result; out[j] at word index j.
REQ-012 SHALL have port busy  output  1  high while a pass is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when all of out is valid.

Function
REQ-014 SHALL implement FSM states IDLE, MAC, DONE; IDLE->MAC on start sampled high, MAC->DONE after last term of output M_OUTPUT-1, DONE->IDLE unconditionally.
REQ-015 SHALL, on start accepted in IDLE, latch x, w, b into internal registers; changes on x, w, b while busy SHALL have no effect.
REQ-016 SHALL ignore start in MAC and DONE (no queuing).
REQ-017 SHALL use one time-shared multiply-accumulate; one term x[i]*w[j*N_INPUT+i] per MAC cycle, i inner (0..N_INPUT-1), j outer (0..M_OUTPUT-1).
REQ-018 SHALL seed the accumulator with b[j] at the start of each output j.
REQ-019 SHALL form each term as full 2*BITSIZE signed product, arithmetic right shift by FRAC (floor toward minus infinity), keep low BITSIZE bits.
REQ-020 SHALL accumulate modulo 2^BITSIZE (wrap-around, no saturation).
REQ-021 SHALL write out[j] on the MAC cycle that adds term i=N_INPUT-1; other out words SHALL hold their previous values.
REQ-022 SHALL spend exactly N_INPUT*M_OUTPUT cycles in MAC; with start sampled at edge 0, done SHALL be high in cycle N_INPUT*M_OUTPUT+1 (37 at defaults) for exactly one cycle.
REQ-023 SHALL drive busy high in MAC and DONE, low in IDLE.
REQ-024 SHALL accept a new start in the IDLE cycle after DONE; with start held high the pass period SHALL be N_INPUT*M_OUTPUT+2 cycles.
REQ-025 SHALL hold out stable from done until the next pass overwrites word 0.

Reset
REQ-026 SHALL, on rst high, immediately force state IDLE, busy 0, done 0, out all zero, counters and accumulator zero, latched operands zero.
REQ-027 SHALL, when rst asserts mid-pass, abandon the pass with no done pulse; first start after rst deassertion SHALL begin a full fresh pass.

Structure
REQ-028 SHALL place FSM state encoding and default N_INPUT/M_OUTPUT/BITSIZE/FRAC constants in shared package encoder_pkg.
REQ-029 SHALL instantiate one sub-module fxp_mac (combinational: acc, a, b -> acc + trunc(a*b)) implementing REQ-019/020.
REQ-030 SHALL size i and j counters as $clog2 of N_INPUT and M_OUTPUT (minimum 1 bit).

Verification
REQ-031 SHALL cover: all x=0x0400_0000, all w=0x0400_0000, b=0, start pulse at edge 0 -> out[j]=0x2400_0000 all j, done only in cycle 37, busy high cycles 1-37.
REQ-032 SHALL cover: x=0x0800_0000 (2.0), w=0xFE00_0000 (-0.5), b[j]=j*0x0400_0000 -> out[0]=0xDC00_0000, out[3]=0xE800_0000.
REQ-033 SHALL cover: x=0xFFFF_FFFF, w=0x0000_0001, b=0 -> every out[j]=0xFFFF_FFF7 (floor truncation); x=w=0x0000_0001 -> out[j]=b[j].
REQ-034 SHALL cover: start pulsed in cycles 5 and 37 of a pass, x changed in cycle 10 -> single done at 37, results from operands latched at edge 0.
REQ-035 SHALL cover: rst asserted in MAC cycle 10 -> out=0, busy=0 same cycle, no done; restart -> correct results, done 37 cycles after new start.
REQ-036 SHALL cover: start held high 100 cycles -> done pulses at cycles 37 and 75.
